// File: rtl/stage_ex.sv
// MIPS execute stage: logic/shift/arith/move ops, single-cycle multiply and a
// 32-step restoring divider that owns the HI/LO pair and stalls upstream.
module stage_ex #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [3:0]  ex_alu_type,
    input  logic [8:0]  ex_operator,
    input  logic [31:0] ex_operand_1,
    input  logic [31:0] ex_operand_2,
    input  logic [5:0]  ex_register_write_address,
    input  logic        ex_register_write_enable,
    output logic [5:0]  register_write_address,
    output logic        register_write_enable,
    output logic [31:0] register_write_data,
    output logic        stall_request,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] TYPE_LOGIC  = 4'd1;
    localparam logic [3:0] TYPE_SHIFT  = 4'd2;
    localparam logic [3:0] TYPE_ARITH  = 4'd3;
    localparam logic [3:0] TYPE_MOVE   = 4'd4;
    localparam logic [3:0] TYPE_MULDIV = 4'd5;

    localparam logic [8:0] OP_AND   = 9'h001;
    localparam logic [8:0] OP_OR    = 9'h002;
    localparam logic [8:0] OP_XOR   = 9'h003;
    localparam logic [8:0] OP_NOR   = 9'h004;
    localparam logic [8:0] OP_SLL   = 9'h010;
    localparam logic [8:0] OP_SRL   = 9'h011;
    localparam logic [8:0] OP_SRA   = 9'h012;
    localparam logic [8:0] OP_ADDU  = 9'h020;
    localparam logic [8:0] OP_SUBU  = 9'h021;
    localparam logic [8:0] OP_SLT   = 9'h022;
    localparam logic [8:0] OP_SLTU  = 9'h023;
    localparam logic [8:0] OP_MFHI  = 9'h030;
    localparam logic [8:0] OP_MFLO  = 9'h031;
    localparam logic [8:0] OP_MTHI  = 9'h032;
    localparam logic [8:0] OP_MTLO  = 9'h033;
    localparam logic [8:0] OP_MULT  = 9'h040;
    localparam logic [8:0] OP_MULTU = 9'h041;
    localparam logic [8:0] OP_DIV   = 9'h042;
    localparam logic [8:0] OP_DIVU  = 9'h043;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DIVIDING = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    localparam int CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] step;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      quotient;
    logic [31:0]      remainder;
    logic [31:0]      divisor;
    logic             negate_quotient;
    logic             negate_remainder;

    logic        is_muldiv;
    logic        is_div;
    logic        is_signed_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic        is_mult;
    logic        sign_1;
    logic        sign_2;
    logic [31:0] magnitude_1;
    logic [31:0] magnitude_2;
    logic [63:0] product;
    logic [32:0] trial;
    logic [31:0] div_lo;
    logic [31:0] div_hi;
    logic [31:0] result;
    logic        writes_gpr;

    assign is_muldiv     = (ex_alu_type == TYPE_MULDIV);
    assign is_div        = is_muldiv && (ex_operator == OP_DIV || ex_operator == OP_DIVU);
    assign is_signed_div = is_muldiv && (ex_operator == OP_DIV);
    assign is_mult       = is_muldiv && (ex_operator == OP_MULT || ex_operator == OP_MULTU);
    assign is_mthi       = (ex_alu_type == TYPE_MOVE) && (ex_operator == OP_MTHI);
    assign is_mtlo       = (ex_alu_type == TYPE_MOVE) && (ex_operator == OP_MTLO);

    assign sign_1      = is_signed_div & ex_operand_1[31];
    assign sign_2      = is_signed_div & ex_operand_2[31];
    assign magnitude_1 = sign_1 ? (32'd0 - ex_operand_1) : ex_operand_1;
    assign magnitude_2 = sign_2 ? (32'd0 - ex_operand_2) : ex_operand_2;

    // Sign-extend to 64 bits for MULT so the low 64 bits of the product are exact.
    always_comb begin
        if (ex_operator == OP_MULT)
            product = {{32{ex_operand_1[31]}}, ex_operand_1} * {{32{ex_operand_2[31]}}, ex_operand_2};
        else
            product = {32'd0, ex_operand_1} * {32'd0, ex_operand_2};
    end

    // Restoring step: shift the next dividend bit into the partial remainder and
    // keep the subtraction only if it did not borrow.
    assign trial  = {remainder, quotient[31]} - {1'b0, divisor};
    assign div_lo = negate_quotient  ? (32'd0 - quotient)  : quotient;
    assign div_hi = negate_remainder ? (32'd0 - remainder) : remainder;

    always_comb begin
        result     = '0;
        writes_gpr = 1'b1;
        case (ex_alu_type)
            TYPE_LOGIC: begin
                case (ex_operator)
                    OP_AND:  result = ex_operand_1 & ex_operand_2;
                    OP_OR:   result = ex_operand_1 | ex_operand_2;
                    OP_XOR:  result = ex_operand_1 ^ ex_operand_2;
                    OP_NOR:  result = ~(ex_operand_1 | ex_operand_2);
                    default: result = '0;
                endcase
            end
            TYPE_SHIFT: begin
                case (ex_operator)
                    OP_SLL:  result = ex_operand_1 << ex_operand_2[4:0];
                    OP_SRL:  result = ex_operand_1 >> ex_operand_2[4:0];
                    OP_SRA:  result = $unsigned($signed(ex_operand_1) >>> ex_operand_2[4:0]);
                    default: result = '0;
                endcase
            end
            TYPE_ARITH: begin
                case (ex_operator)
                    OP_ADDU: result = ex_operand_1 + ex_operand_2;
                    OP_SUBU: result = ex_operand_1 - ex_operand_2;
                    OP_SLT:  result = {31'd0, $signed(ex_operand_1) < $signed(ex_operand_2)};
                    OP_SLTU: result = {31'd0, ex_operand_1 < ex_operand_2};
                    default: result = '0;
                endcase
            end
            TYPE_MOVE: begin
                case (ex_operator)
                    OP_MFHI: result = hi_reg;
                    OP_MFLO: result = lo_reg;
                    OP_MTHI: writes_gpr = 1'b0;
                    OP_MTLO: writes_gpr = 1'b0;
                    default: result = '0;
                endcase
            end
            TYPE_MULDIV: begin
                if (is_mult || is_div)
                    writes_gpr = 1'b0;
            end
            default: result = '0;
        endcase
    end

    assign register_write_data    = reset ? result : '0;
    assign register_write_address = reset ? ex_register_write_address : '0;
    assign register_write_enable  = reset & ex_register_write_enable & ~flush & writes_gpr;
    assign hi = hi_reg;
    assign lo = lo_reg;

    // Stall covers the issue cycle and every dividing cycle; DONE lets upstream advance.
    always_comb begin
        stall_request = 1'b0;
        if (reset && !flush) begin
            case (state)
                ST_IDLE:     stall_request = is_div;
                ST_DIVIDING: stall_request = 1'b1;
                default:     stall_request = 1'b0;
            endcase
        end
    end

    // Divider FSM plus every HI/LO write; flush abandons whatever is in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            step             <= '0;
            hi_reg           <= '0;
            lo_reg           <= '0;
            quotient         <= '0;
            remainder        <= '0;
            divisor          <= '0;
            negate_quotient  <= 1'b0;
            negate_remainder <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_div) begin
                        step <= '0;
                        if (ex_operand_2 == 32'd0) begin
                            quotient         <= 32'hFFFF_FFFF;
                            remainder        <= ex_operand_1;
                            negate_quotient  <= 1'b0;
                            negate_remainder <= 1'b0;
                            state            <= ST_DONE;
                        end else begin
                            quotient         <= magnitude_1;
                            remainder        <= '0;
                            divisor          <= magnitude_2;
                            negate_quotient  <= sign_1 ^ sign_2;
                            negate_remainder <= sign_1;
                            state            <= ST_DIVIDING;
                        end
                    end else if (is_mult) begin
                        hi_reg <= product[63:32];
                        lo_reg <= product[31:0];
                    end else if (is_mthi) begin
                        hi_reg <= ex_operand_1;
                    end else if (is_mtlo) begin
                        lo_reg <= ex_operand_1;
                    end
                end
                ST_DIVIDING: begin
                    if (!trial[32]) begin
                        remainder <= trial[31:0];
                        quotient  <= {quotient[30:0], 1'b1};
                    end else begin
                        remainder <= {remainder[30:0], quotient[31]};
                        quotient  <= {quotient[30:0], 1'b0};
                    end
                    step <= step + 1'b1;
                    if (step == LAST_STEP)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    hi_reg <= div_hi;
                    lo_reg <= div_lo;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed cases plus randomized ops against
// an arithmetic reference model of the result, HI/LO and divider stall length.
module tb_stage_ex;

    localparam logic [3:0] T_NOP    = 4'd0;
    localparam logic [3:0] T_LOGIC  = 4'd1;
    localparam logic [3:0] T_SHIFT  = 4'd2;
    localparam logic [3:0] T_ARITH  = 4'd3;
    localparam logic [3:0] T_MOVE   = 4'd4;
    localparam logic [3:0] T_MULDIV = 4'd5;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [3:0]  ex_alu_type;
    logic [8:0]  ex_operator;
    logic [31:0] ex_operand_1;
    logic [31:0] ex_operand_2;
    logic [5:0]  ex_register_write_address;
    logic        ex_register_write_enable;
    logic [5:0]  register_write_address;
    logic        register_write_enable;
    logic [31:0] register_write_data;
    logic        stall_request;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    logic [12:0] op_table [20] = '{
        {T_LOGIC, 9'h001}, {T_LOGIC, 9'h002}, {T_LOGIC, 9'h003}, {T_LOGIC, 9'h004},
        {T_SHIFT, 9'h010}, {T_SHIFT, 9'h011}, {T_SHIFT, 9'h012},
        {T_ARITH, 9'h020}, {T_ARITH, 9'h021}, {T_ARITH, 9'h022}, {T_ARITH, 9'h023},
        {T_MOVE, 9'h030},  {T_MOVE, 9'h031},  {T_MOVE, 9'h032},  {T_MOVE, 9'h033},
        {T_MULDIV, 9'h040}, {T_MULDIV, 9'h041}, {T_NOP, 9'h000}, {T_LOGIC, 9'h0FF},
        {T_ARITH, 9'h030}
    };

    stage_ex #(.DIV_STEPS(32)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush                     (flush),
        .ex_alu_type               (ex_alu_type),
        .ex_operator               (ex_operator),
        .ex_operand_1              (ex_operand_1),
        .ex_operand_2              (ex_operand_2),
        .ex_register_write_address (ex_register_write_address),
        .ex_register_write_enable  (ex_register_write_enable),
        .register_write_address    (register_write_address),
        .register_write_enable     (register_write_enable),
        .register_write_data       (register_write_data),
        .stall_request             (stall_request),
        .hi                        (hi),
        .lo                        (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expData(input logic [3:0] t, input logic [8:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (t == T_LOGIC && op == 9'h001) return a & b;
        if (t == T_LOGIC && op == 9'h002) return a | b;
        if (t == T_LOGIC && op == 9'h003) return a ^ b;
        if (t == T_LOGIC && op == 9'h004) return ~(a | b);
        if (t == T_SHIFT && op == 9'h010) return a << sh;
        if (t == T_SHIFT && op == 9'h011) return a >> sh;
        if (t == T_SHIFT && op == 9'h012) return a[31] ? ~((~a) >> sh) : (a >> sh);
        if (t == T_ARITH && op == 9'h020) return a + b;
        if (t == T_ARITH && op == 9'h021) return a - b;
        if (t == T_ARITH && op == 9'h022)
            return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
        if (t == T_ARITH && op == 9'h023) return (a < b) ? 32'd1 : 32'd0;
        if (t == T_MOVE && op == 9'h030) return model_hi;
        if (t == T_MOVE && op == 9'h031) return model_lo;
        return 32'd0;
    endfunction

    function automatic logic writesGpr(input logic [3:0] t, input logic [8:0] op);
        if (t == T_MOVE && (op == 9'h032 || op == 9'h033)) return 1'b0;
        if (t == T_MULDIV && op >= 9'h040 && op <= 9'h043) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] randVal();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    // Checks HI/LO settled from the previous instruction, then presents the next one.
    task automatic applyStimulus(input logic [3:0] t, input logic [8:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [5:0] addr, input logic we,
                                 input logic fl);
        @(negedge clock);
        checkOutput("hi_reg", hi, model_hi);
        checkOutput("lo_reg", lo, model_lo);
        ex_alu_type = t;
        ex_operator = op;
        ex_operand_1 = a;
        ex_operand_2 = b;
        ex_register_write_address = addr;
        ex_register_write_enable = we;
        flush = fl;
    endtask

    task automatic doOp(input string tag, input logic [3:0] t, input logic [8:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic fl);
        logic [5:0]  addr;
        logic        we;
        logic [63:0] prod;
        addr = 6'($urandom);
        we = ($urandom_range(0, 3) != 0);
        applyStimulus(t, op, a, b, addr, we, fl);
        #1;
        checkOutput({tag, "_data"}, register_write_data, expData(t, op, a, b));
        checkOutput({tag, "_we"}, register_write_enable, we & ~fl & writesGpr(t, op));
        checkOutput({tag, "_addr"}, register_write_address, addr);
        checkOutput({tag, "_stall"}, stall_request, 1'b0);
        if (!fl) begin
            if (t == T_MOVE && op == 9'h032) model_hi = a;
            if (t == T_MOVE && op == 9'h033) model_lo = a;
            if (t == T_MULDIV && op == 9'h040) begin
                prod = 64'(longint'($signed(a)) * longint'($signed(b)));
                {model_hi, model_lo} = prod;
            end
            if (t == T_MULDIV && op == 9'h041) begin
                prod = {32'd0, a} * {32'd0, b};
                {model_hi, model_lo} = prod;
            end
        end
    endtask

    // abort_kind: 0 none, 1 flush, 2 reset pulse, applied after abort_after stalled cycles.
    task automatic runDivide(input string tag, input logic [8:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int abort_kind, input int abort_after);
        int     stall_cycles;
        logic   finished;
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        applyStimulus(T_MULDIV, op, a, b, 6'd3, 1'b1, 1'b0);
        #1;
        checkOutput({tag, "_issue_we"}, register_write_enable, 1'b0);
        stall_cycles = 0;
        finished = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (abort_kind != 0 && stall_cycles == abort_after) begin
                if (abort_kind == 1) begin
                    flush = 1'b1;
                    #1;
                    checkOutput({tag, "_flush_stall"}, stall_request, 1'b0);
                    @(negedge clock);
                    flush = 1'b0;
                    ex_alu_type = T_NOP;
                    ex_operator = 9'h000;
                    #1;
                    checkOutput({tag, "_after_flush_stall"}, stall_request, 1'b0);
                end else begin
                    reset = 1'b0;
                    #1;
                    checkOutput({tag, "_reset_stall"}, stall_request, 1'b0);
                    checkOutput({tag, "_reset_hi"}, hi, 32'd0);
                    checkOutput({tag, "_reset_lo"}, lo, 32'd0);
                    model_hi = '0;
                    model_lo = '0;
                    @(negedge clock);
                    reset = 1'b1;
                    ex_alu_type = T_NOP;
                    ex_operator = 9'h000;
                    #1;
                    checkOutput({tag, "_after_reset_stall"}, stall_request, 1'b0);
                end
                return;
            end
            if (!stall_request) begin
                finished = 1'b1;
                break;
            end
            stall_cycles++;
            @(negedge clock);
            #1;
        end
        checkOutput({tag, "_completes"}, finished, 1'b1);
        checkOutput({tag, "_stall_cycles"}, stall_cycles, (b == 0) ? 1 : 33);
        checkOutput({tag, "_done_we"}, register_write_enable, 1'b0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == 9'h043) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        model_hi = r;
        model_lo = q;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        ex_alu_type = T_ARITH;
        ex_operator = 9'h020;
        ex_operand_1 = 32'h1234_5678;
        ex_operand_2 = 32'h1;
        ex_register_write_address = 6'd5;
        ex_register_write_enable = 1'b1;
        #3;
        checkOutput("reset_data", register_write_data, 32'd0);
        checkOutput("reset_we", register_write_enable, 1'b0);
        checkOutput("reset_addr", register_write_address, 6'd0);
        checkOutput("reset_stall", stall_request, 1'b0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        doOp("addu_wrap", T_ARITH, 9'h020, 32'hFFFF_FFFF, 32'h2, 1'b0);
        doOp("slt_neg", T_ARITH, 9'h022, 32'hFFFF_FFFF, 32'h1, 1'b0);
        doOp("sltu_big", T_ARITH, 9'h023, 32'hFFFF_FFFF, 32'h1, 1'b0);
        doOp("sra", T_SHIFT, 9'h012, 32'h8000_0000, 32'd4, 1'b0);
        doOp("srl", T_SHIFT, 9'h011, 32'h8000_0000, 32'd4, 1'b0);
        doOp("mult", T_MULDIV, 9'h040, 32'hFFFF_FFFF, 32'h2, 1'b0);
        doOp("multu", T_MULDIV, 9'h041, 32'hFFFF_FFFF, 32'h2, 1'b0);
        runDivide("divu_100_7", 9'h043, 32'd100, 32'd7, 0, 0);
        runDivide("div_m7_2", 9'h042, 32'hFFFF_FFF9, 32'd2, 0, 0);
        runDivide("div_by_zero", 9'h042, 32'd5, 32'd0, 0, 0);
        doOp("mfhi_after_div0", T_MOVE, 9'h030, 32'd0, 32'd0, 1'b0);
        runDivide("divu_flush", 9'h043, 32'd1000, 32'd3, 1, 11);
        doOp("mflo_after_flush", T_MOVE, 9'h031, 32'd0, 32'd0, 1'b0);
        runDivide("divu_reset", 9'h043, 32'd1000, 32'd3, 2, 11);
        runDivide("divu_after_reset", 9'h043, 32'd1000, 32'd3, 0, 0);
        doOp("mthi", T_MOVE, 9'h032, 32'hCAFE_0001, 32'd0, 1'b0);
        doOp("mfhi_fwd", T_MOVE, 9'h030, 32'd0, 32'd0, 1'b0);
        doOp("mtlo_flushed", T_MOVE, 9'h033, 32'hDEAD_BEEF, 32'd0, 1'b1);
        doOp("mult_flushed", T_MULDIV, 9'h040, 32'h7, 32'h9, 1'b1);
        runDivide("div_minint", 9'h042, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [12:0] entry;
            if (i % 10 == 9) begin
                runDivide("rand_div", ($urandom_range(0, 1) != 0) ? 9'h042 : 9'h043,
                          randVal(), randVal(), 0, 0);
            end else begin
                entry = op_table[$urandom_range(0, 19)];
                doOp("rand_op", entry[12:9], entry[8:0], randVal(), randVal(),
                     ($urandom_range(0, 7) == 0));
            end
        end

        applyStimulus(T_NOP, 9'h000, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
